// File: rtl/paritybit_frame_tx.sv
// Serial frame transmitter: start, 4 data bits LSB first, parity, stop.
// Each bit is held for CLKS_PER_BIT clocks. Parity comes from paritybit_generator.

module paritybit_generator (
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic d,
   output logic e
);
   assign e = a ^ b ^ c ^ d;
endmodule

module paritybit_frame_tx #(
   parameter int CLKS_PER_BIT = 10,
   parameter bit ODD_PARITY   = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       tx,
   output logic       busy,
   output logic       done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [1:0]      idx, idx_n;
   logic [3:0]      data_q;
   logic            par;
   logic            accept;

   paritybit_generator u_par (
      .a(data_q[3]),
      .b(data_q[2]),
      .c(data_q[1]),
      .d(data_q[0]),
      .e(par)
   );

   assign accept = in_valid && (state == IDLE);

   // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      idx_n   = idx;
      if (state == IDLE) begin
         if (accept) begin
            state_n = START;
            cnt_n   = '0;
            idx_n   = 2'd0;
         end
      end else if (cnt == CNT_MAX) begin
         cnt_n = '0;
         case (state)
            START:   begin state_n = DATA; idx_n = 2'd0; end
            DATA:    begin
               idx_n = idx + 2'd1;
               if (idx == 2'd3) state_n = PARITY;
            end
            PARITY:  state_n = STOP;
            STOP:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end else begin
         cnt_n = cnt + 1'b1;
      end
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   // NOTE: state and outputs update with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         idx      <= 2'd0;
         tx       <= 1'b1;
         in_ready <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         idx      <= idx_n;
         in_ready <= (state_n == IDLE);
         busy     <= (state_n != IDLE);
         done     <= (state_n == STOP) && (cnt_n == CNT_MAX);
         case (state_n)
            START:   tx <= 1'b0;
            DATA:    tx <= data_q[idx_n];
            PARITY:  tx <= par ^ ODD_PARITY;
            default: tx <= 1'b1;
         endcase
      end
   end

   // NOTE: data_q is a plain payload register; it is always written before use, so it has no reset.
   always_ff @(posedge clk) begin
      if (!rst && accept) data_q <= in_data;
   end
endmodule
